// File: rtl/alu_seq_pkg.sv
// Shared op-codes, FSM encoding and widths for the alu_seq sequential ALU.
// The multiplier states are only reached when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_PASS = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd8;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// The first partial product is folded into the start edge, so the product is final WIDTH edges after start.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               w_run;

  assign w_run = r_busy && (r_cnt != CNT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(1);
    end else if (w_run) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Datapath is not reset: it is always reloaded by start before being observed.
  always_ff @(posedge clk) begin
    if (start) begin
      r_prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      r_mplier <= {1'b0, b[WIDTH-1:1]};
    end else if (w_run) begin
      r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign last = w_run && (r_cnt == CNT_LAST);
  assign done = r_busy && (r_cnt == CNT_FULL);
  assign prod = r_prod;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with accumulator, valid/ready handshakes and registered flags.
// Define ALU_SEQ_MUL_EN to enable the multi-cycle multiply on op 9.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             cin,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             eqv,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             ovf;
  } alu_res_t;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // SUB is computed as x + ~y + cin, so its overflow is the add overflow against ~y.
  function automatic alu_res_t alu_eval(input logic [OP_W-1:0]  opc,
                                        input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y,
                                        input logic             ci);
    alu_res_t       r;
    logic [WIDTH:0] s;
    r   = '0;
    r.f = x;
    s   = '0;
    case (opc)
      OP_ADD: begin
        s      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        r.f    = s[WIDTH-1:0];
        r.cout = s[WIDTH];
        r.ovf  = add_ovf(x, y, s[WIDTH-1:0]);
      end
      OP_SUB: begin
        s      = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, ci};
        r.f    = s[WIDTH-1:0];
        r.cout = s[WIDTH];
        r.ovf  = add_ovf(x, ~y, s[WIDTH-1:0]);
      end
      OP_AND:  r.f = x & y;
      OP_OR:   r.f = x | y;
      OP_XOR:  r.f = x ^ y;
      OP_NOT:  r.f = ~x;
      OP_PASS: r.f = y;
      OP_SHL: begin
        r.f    = {x[WIDTH-2:0], ci};
        r.cout = x[WIDTH-1];
      end
      OP_SHR: begin
        r.f    = {ci, x[WIDTH-1:1]};
        r.cout = x[0];
      end
      default: r.f = x;
    endcase
    return r;
  endfunction

  logic             r_out_valid;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic             r_eqv;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_a;
  logic             w_idle;
  logic             w_accept;
  alu_res_t         w_res;
  logic             w_load;
  logic [WIDTH-1:0] w_f;
  logic             w_cout;
  logic             w_ovf;
  logic             w_eqv;

  assign w_a      = use_acc ? r_acc : a;
  assign in_ready = !rst && w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_res    = alu_eval(op, w_a, b, cin);

`ifdef ALU_SEQ_MUL_EN
  state_t             r_state;
  state_t             w_state_nx;
  logic               w_mul_start;
  logic               w_mul_last;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic               r_eqv_mul;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_mul_start = 1'b0;
    w_load      = 1'b0;
    w_f         = w_res.f;
    w_cout      = w_res.cout;
    w_ovf       = w_res.ovf;
    w_eqv       = (w_a == b);
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (op == OP_MUL) begin
            w_mul_start = 1'b1;
            w_state_nx  = ST_MUL;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_last) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (w_mul_done) begin
          w_load     = 1'b1;
          w_f        = w_prod[WIDTH-1:0];
          w_cout     = |w_prod[2*WIDTH-1:WIDTH];
          w_ovf      = 1'b0;
          w_eqv      = r_eqv_mul;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign w_idle = (r_state == ST_IDLE);

  // eqv belongs to the accept-time operands, which are gone by the time the product is ready.
  always_ff @(posedge clk) begin
    if (w_mul_start) r_eqv_mul <= (w_a == b);
  end

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (w_a),
    .b     (b),
    .last  (w_mul_last),
    .done  (w_mul_done),
    .prod  (w_prod)
  );
`else
  assign w_idle = 1'b1;
  assign w_load = w_accept;
  assign w_f    = w_res.f;
  assign w_cout = w_res.cout;
  assign w_ovf  = w_res.ovf;
  assign w_eqv  = (w_a == b);
`endif

  // Stage p1: result, flag and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_cout      <= 1'b0;
      r_eqv       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_f         <= w_f;
      r_cout      <= w_cout;
      r_eqv       <= w_eqv;
      r_zero      <= (w_f == '0);
      r_neg       <= w_f[WIDTH-1];
      r_ovf       <= w_ovf;
      r_acc       <= w_f;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign cout      = r_cout;
  assign eqv       = r_eqv;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;
  assign acc       = r_acc;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases plus randomized traffic against an arithmetic model.
// Follows ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         cin;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout;
  logic         eqv;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic [W-1:0] acc;

  int checks = 0;
  int errors = 0;

  // Reference model state: the visible outputs plus a countdown for a multiply in flight.
  int m_valid, m_f, m_cout, m_eqv, m_zero, m_neg, m_ovf, m_acc;
  int m_rem, m_pf, m_pc, m_pe;

  logic [21:0] dut_vec;
  assign dut_vec = {out_valid, f, cout, eqv, zero, neg, ovf, acc};

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout      (cout),
    .eqv       (eqv),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  function automatic void ref_alu(input int opc, input int x, input int y, input int ci,
                                  output int rf, output int rc, output int rv);
    int sx, sy, s;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    rf = x; rc = 0; rv = 0;
    case (opc)
      0: begin
        s = x + y + ci; rf = s % 256; rc = s / 256;
        s = sx + sy + ci; rv = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        s = x + (255 - y) + ci; rf = s % 256; rc = s / 256;
        s = sx - sy - 1 + ci; rv = (s > 127 || s < -128) ? 1 : 0;
      end
      2: rf = x & y;
      3: rf = x | y;
      4: rf = x ^ y;
      5: rf = 255 - x;
      6: rf = y;
      7: begin rf = (x * 2 + ci) % 256; rc = x / 128; end
      8: begin rf = x / 2 + ci * 128; rc = x % 2; end
`ifdef ALU_SEQ_MUL_EN
      9: begin s = x * y; rf = s % 256; rc = (s / 256 != 0) ? 1 : 0; end
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [21:0] model_vec();
    return {1'(m_valid), 8'(m_f), 1'(m_cout), 1'(m_eqv), 1'(m_zero), 1'(m_neg), 1'(m_ovf), 8'(m_acc)};
  endfunction

  function automatic int exp_ready();
    return (!rst && m_rem == 0 && (!m_valid || out_ready)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_f = 0; m_cout = 0; m_eqv = 0; m_zero = 0; m_neg = 0; m_ovf = 0; m_acc = 0;
    m_rem = 0; m_pf = 0; m_pc = 0; m_pe = 0;
  endtask

  task automatic model_load(input int rf, input int rc, input int rv, input int re);
    m_valid = 1; m_f = rf; m_cout = rc; m_ovf = rv; m_eqv = re;
    m_zero = (rf == 0) ? 1 : 0; m_neg = (rf >= 128) ? 1 : 0; m_acc = rf;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    int take, x, rf, rc, rv;
    if (rst) begin
      model_reset();
      return;
    end
    take = in_valid && exp_ready();
    x = use_acc ? m_acc : int'(a);
    if (m_valid && out_ready) m_valid = 0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) model_load(m_pf, m_pc, 0, m_pe);
    end else if (take) begin
      ref_alu(int'(op), x, int'(b), int'(cin), rf, rc, rv);
`ifdef ALU_SEQ_MUL_EN
      if (op == 4'd9) begin
        m_pf = rf; m_pc = rc; m_pe = (x == int'(b)) ? 1 : 0; m_rem = W;
      end else
`endif
      model_load(rf, rc, rv, (x == int'(b)) ? 1 : 0);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [3:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic c, input logic ua, input logic ordy);
    in_valid = v; op = o; a = xa; b = xb; cin = c; use_acc = ua; out_ready = ordy;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    model_reset();
    cycle(); cycle();
    checks++;
    if (dut_vec !== 22'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", dut_vec, 22'h0);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_release: got %b want 1", in_ready);
    end
    set_op(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    cycle();
    // rst must win over a pending result and a new offer on the same edge
    rst = 1'b1;
    set_op(1'b1, 4'd0, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0);
    cycle();
    checks++;
    if (dut_vec !== 22'h0) begin
      errors++; $display("FAIL reset_dominates: got %h want %h", dut_vec, 22'h0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_add_sub();
    do_reset(1);
    set_op(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    cycle();
    checks++;
    if ({out_valid, f, cout, zero, ovf} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_ff_01: got v=%b f=%h c=%b z=%b o=%b want v=1 f=00 c=1 z=1 o=0",
                         out_valid, f, cout, zero, ovf);
    end
    set_op(1'b1, 4'd1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
    cycle();
    checks++;
    if ({f, cout, ovf, neg, eqv} !== {8'h7F, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_80_01: got f=%h c=%b o=%b n=%b e=%b want f=7f c=1 o=1 n=0 e=0",
                         f, cout, ovf, neg, eqv);
    end
    set_op(1'b1, 4'd1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1);
    cycle();
    checks++;
    if ({f, eqv, zero} !== {8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_equal: got f=%h e=%b z=%b want f=00 e=1 z=1", f, eqv, zero);
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_clears_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 4'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first_ready: got %b want 1", in_ready);
    end
    cycle();
    set_op(1'b1, 4'd4, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall_ready cycle %0d: got %b want 0", i, in_ready);
      end
      cycle();
      checks++;
      if ({out_valid, f} !== {1'b1, 8'h30}) begin
        errors++; $display("FAIL bp_hold cycle %0d: got v=%b f=%h want v=1 f=30", i, out_valid, f);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_drain_ready: got %b want 1", in_ready);
    end
    cycle();
    checks++;
    if ({out_valid, f} !== {1'b1, 8'hF0}) begin
      errors++; $display("FAIL bp_second_result: got v=%b f=%h want v=1 f=f0", out_valid, f);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_accumulate();
    logic [W-1:0] want;
    do_reset(2);
    for (int i = 1; i <= 3; i++) begin
      set_op(1'b1, 4'd0, 8'($urandom), 8'h05, 1'b0, 1'b1, 1'b1);
      cycle();
      want = 8'(5 * i);
      checks++;
      if (f !== want) begin
        errors++; $display("FAIL acc_add step %0d: got f=%h want %h", i, f, want);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc !== 8'h0F) begin
      errors++; $display("FAIL acc_final: got %h want 0f", acc);
    end
    cycle();
  endtask

  task automatic test_mul();
    do_reset(1);
    set_op(1'b1, 4'd9, 8'h10, 8'h11, 1'b0, 1'b0, 1'b1);
    cycle();
`ifdef ALU_SEQ_MUL_EN
    set_op(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    for (int k = 2; k <= W + 1; k++) begin
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        errors++; $display("FAIL mul_busy edge %0d: got rdy=%b v=%b want rdy=0 v=0", k, in_ready, out_valid);
      end
      cycle();
    end
    in_valid = 1'b0;
`else
    in_valid = 1'b0;
`endif
    checks++;
    if ({out_valid, f, cout} !== {1'b1, 8'h10, `ifdef ALU_SEQ_MUL_EN 1'b1 `else 1'b0 `endif}) begin
      errors++; $display("FAIL mul_result: got v=%b f=%h c=%b want v=1 f=10", out_valid, f, cout);
    end
    cycle();
  endtask

  task automatic test_abort();
    do_reset(1);
    set_op(1'b1, 4'd9, 8'h23, 8'h45, 1'b0, 1'b0, 1'b1);
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({out_valid, acc} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL abort_state: got v=%b acc=%h want v=0 acc=00", out_valid, acc);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < W + 3; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL abort_late_result cycle %0d: got v=%b f=%h want v=0", i, out_valid, f);
      end
    end
  endtask

  task automatic test_random();
    logic r_exp;
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 4'($urandom_range(0, 15));
      a         = 8'($urandom);
      b         = ($urandom_range(0, 5) == 0) ? a : 8'($urandom);
      cin       = 1'($urandom);
      use_acc   = 1'($urandom);
      #1;
      r_exp = 1'(exp_ready());
      checks++;
      if (in_ready !== r_exp) begin
        errors++; $display("FAIL rand_in_ready cycle %0d: got %b want %b", i, in_ready, r_exp);
      end
      cycle();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL rand_outputs cycle %0d op %0d: got %h want %h", i, op, dut_vec, model_vec());
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_op(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_accumulate();
    test_mul();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
